multi_drop_fifo_bus: RTL and testbench

//   Parametrised multi-drop bus receiver: one shared source bus feeds NUM_DROPS

---
 rtl/multi_drop_fifo_bus.sv | 134 +++++++++++++
 tb/tb_multi_drop_fifo_bus.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_drop_fifo_bus.sv
// multi_drop_fifo_bus: one shared source bus fanned out to NUM_DROPS independent
// first-word-fall-through FIFOs. Handles unicast/broadcast selects, all-or-nothing
// broadcast back-pressure, and illegal-select detection with a saturating counter.

// Per-drop FWFT FIFO. The caller never pushes when full.
module mdfb_drop_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_pop;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && valid_o;
  // Head is gated to zero when empty so stale storage never leaks out.
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  // Next-state pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage write; deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

module multi_drop_fifo_bus #(
  parameter int DATA_W    = 8,
  parameter int NUM_DROPS = 3,
  parameter int DEPTH     = 4,
  parameter bit BCAST_EN  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           bus_data,
  input  logic                        bus_valid,
  input  logic [NUM_DROPS-1:0]        bus_sel,
  input  logic                        bus_bcast,
  output logic                        bus_ready,
  output logic [NUM_DROPS*DATA_W-1:0] drop_data,
  output logic [NUM_DROPS-1:0]        drop_valid,
  input  logic [NUM_DROPS-1:0]        drop_ready,
  output logic [NUM_DROPS-1:0]        drop_full,
  output logic                        sel_err,
  output logic [7:0]                  err_cnt
);
  logic                 sel_onehot, legal;
  logic [NUM_DROPS-1:0] tgt, push;
  logic                 sel_err_d, sel_err_q;
  logic [7:0]           err_cnt_d, err_cnt_q;

  assign sel_onehot = (bus_sel != '0) && ((bus_sel & (bus_sel - 1'b1)) == '0);
  assign legal      = bus_bcast ? BCAST_EN : sel_onehot;
  assign tgt        = bus_bcast ? '1 : bus_sel;
  // Ready never looks at bus_valid and never counts on a same-cycle pop; a
  // broadcast waits until every drop has room.
  assign bus_ready  = legal && ((tgt & drop_full) == '0);
  assign push       = (bus_valid && bus_ready) ? tgt : '0;

  mdfb_drop_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_drop [NUM_DROPS-1:0] (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (drop_ready),
    .wdata_i (bus_data),
    .data_o  (drop_data),
    .valid_o (drop_valid),
    .full_o  (drop_full)
  );

  // Error detection: only an offered transfer with a bad select counts.
  always_comb begin
    sel_err_d = bus_valid && !legal;
    err_cnt_d = err_cnt_q;
    if (sel_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Registered error pulse and saturating counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      sel_err_q <= sel_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign sel_err = sel_err_q;
  assign err_cnt = err_cnt_q;

  // A stalled offer must keep its payload and select until accepted or withdrawn.
  a_src_stable: assert property (@(posedge clk) disable iff (rst)
    (bus_valid && !bus_ready) |=> (!bus_valid || $stable({bus_data, bus_sel, bus_bcast})));
endmodule

// File: tb/tb_multi_drop_fifo_bus.sv
// Bench for multi_drop_fifo_bus: a negedge scoreboard models every drop FIFO as a
// queue and checks ready/valid/full/data/error outputs each cycle, alongside a
// select-pattern vector table and hand-written corner-case sequences.
module tb_multi_drop_fifo_bus;
  localparam int DW = 8;
  localparam int ND = 3;
  localparam int DP = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DW-1:0]    bus_data = '0;
  logic             bus_valid = 1'b0;
  logic [ND-1:0]    bus_sel = '0;
  logic             bus_bcast = 1'b0;
  logic             bus_ready;
  logic [ND*DW-1:0] drop_data;
  logic [ND-1:0]    drop_valid;
  logic [ND-1:0]    drop_ready = '0;
  logic [ND-1:0]    drop_full;
  logic             sel_err;
  logic [7:0]       err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  multi_drop_fifo_bus #(.DATA_W(DW), .NUM_DROPS(ND), .DEPTH(DP), .BCAST_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .bus_data(bus_data), .bus_valid(bus_valid),
    .bus_sel(bus_sel), .bus_bcast(bus_bcast), .bus_ready(bus_ready),
    .drop_data(drop_data), .drop_valid(drop_valid), .drop_ready(drop_ready),
    .drop_full(drop_full), .sel_err(sel_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dd(input int i);
    return drop_data[i*DW +: DW];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected contents of each drop as a queue.
  logic [DW-1:0] q [ND][$];
  logic          exp_err;
  int            exp_cnt;

  always @(negedge clk) begin
    logic          lg, rdy;
    logic [ND-1:0] tg;
    if (rst) begin
      for (int i = 0; i < ND; i++) q[i].delete();
      exp_err = 1'b0;
      exp_cnt = 0;
      chk("rst_valid", 32'(drop_valid), 32'd0);
      chk("rst_full",  32'(drop_full),  32'd0);
      chk("rst_err",   32'(sel_err),    32'd0);
      chk("rst_cnt",   32'(err_cnt),    32'd0);
    end else begin
      lg  = bus_bcast ? 1'b1 : ($countones(bus_sel) == 1);
      tg  = bus_bcast ? {ND{1'b1}} : bus_sel;
      rdy = lg;
      for (int i = 0; i < ND; i++) if (tg[i] && q[i].size() == DP) rdy = 1'b0;
      chk("sb_ready",   32'(bus_ready), 32'(rdy));
      chk("sb_sel_err", 32'(sel_err),   32'(exp_err));
      chk("sb_err_cnt", 32'(err_cnt),   32'(exp_cnt));
      for (int i = 0; i < ND; i++) begin
        chk("sb_valid", 32'(drop_valid[i]), 32'(q[i].size() != 0));
        chk("sb_full",  32'(drop_full[i]),  32'(q[i].size() == DP));
        chk("sb_data",  32'(dd(i)), (q[i].size() != 0) ? 32'(q[i][0]) : 32'd0);
        if (q[i].size() != 0 && drop_ready[i]) void'(q[i].pop_front());
      end
      if (bus_valid && rdy)
        for (int i = 0; i < ND; i++) if (tg[i]) q[i].push_back(bus_data);
      exp_err = bus_valid && !lg;
      if (exp_err && exp_cnt < 255) exp_cnt++;
    end
  end

  task automatic do_reset;
    rst = 1'b1;
    bus_valid = 1'b0; bus_sel = '0; bus_bcast = 1'b0; bus_data = '0; drop_ready = '0;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  typedef struct {
    logic [ND-1:0] sel;
    logic          bc;
    logic [DW-1:0] data;
    logic          rdy;
    logic          err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{3'b001, 1'b0, 8'h11, 1'b1, 1'b0};
    tbl[1] = '{3'b000, 1'b0, 8'h22, 1'b0, 1'b1};
    tbl[2] = '{3'b011, 1'b0, 8'h23, 1'b0, 1'b1};
    tbl[3] = '{3'b111, 1'b0, 8'h24, 1'b0, 1'b1};
    tbl[4] = '{3'b100, 1'b0, 8'h33, 1'b1, 1'b0};
    tbl[5] = '{3'b000, 1'b1, 8'h44, 1'b1, 1'b0};
    tbl[6] = '{3'b010, 1'b0, 8'h55, 1'b1, 1'b0};
    tbl[7] = '{3'b101, 1'b1, 8'h66, 1'b1, 1'b0};

    // Reset state
    #2;
    chk("init_valid", 32'(drop_valid), 32'd0);
    chk("init_full",  32'(drop_full),  32'd0);
    chk("init_data",  32'(drop_data),  32'd0);
    do_reset;

    // Select-pattern table, idle cycle between entries
    foreach (tbl[k]) begin
      bus_sel = tbl[k].sel; bus_bcast = tbl[k].bc; bus_data = tbl[k].data; bus_valid = 1'b1;
      #1 chk("tbl_ready", 32'(bus_ready), 32'(tbl[k].rdy));
      tick;
      bus_valid = 1'b0;
      #1 chk("tbl_err", 32'(sel_err), 32'(tbl[k].err));
      tick;
    end
    chk("tbl_err_cnt", 32'(err_cnt), 32'd3);
    chk("tbl_valid", 32'(drop_valid), 32'b111);
    chk("tbl_head0", 32'(dd(0)), 32'h11);
    chk("tbl_head1", 32'(dd(1)), 32'h44);
    chk("tbl_head2", 32'(dd(2)), 32'h33);

    // 1: single unicast write
    do_reset;
    bus_sel = 3'b010; bus_data = 8'hA5; bus_valid = 1'b1;
    #1 chk("t1_ready", 32'(bus_ready), 32'd1);
    tick;
    bus_valid = 1'b0;
    #1;
    chk("t1_valid", 32'(drop_valid), 32'b010);
    chk("t1_d1", 32'(dd(1)), 32'hA5);
    chk("t1_d0", 32'(dd(0)), 32'h00);
    chk("t1_d2", 32'(dd(2)), 32'h00);

    // 2: fill drop 0, back-pressure per target, then drain in order
    do_reset;
    bus_sel = 3'b001; bus_valid = 1'b1;
    for (int d = 1; d <= 4; d++) begin
      bus_data = 8'(d);
      #1 chk("t2_fill_ready", 32'(bus_ready), 32'd1);
      tick;
    end
    bus_valid = 1'b0;
    #1 chk("t2_full", 32'(drop_full), 32'b001);
    chk("t2_ready_sel0", 32'(bus_ready), 32'd0);
    bus_sel = 3'b100;
    #1 chk("t2_ready_sel2", 32'(bus_ready), 32'd1);
    drop_ready = 3'b001;
    for (int d = 1; d <= 4; d++) begin
      #1 chk("t2_pop_data", 32'(dd(0)), 32'(d));
      tick;
    end
    drop_ready = '0;
    #1 chk("t2_empty", 32'(drop_valid), 32'd0);

    // 3: broadcast blocked by one full drop, released after a pop
    do_reset;
    bus_sel = 3'b100; bus_valid = 1'b1;
    for (int d = 0; d < 4; d++) begin
      bus_data = 8'hA0 + 8'(d);
      tick;
    end
    bus_bcast = 1'b1; bus_data = 8'h5C;
    #1 chk("t3_bc_blocked", 32'(bus_ready), 32'd0);
    tick;
    chk("t3_no_write", 32'(drop_valid), 32'b100);
    drop_ready = 3'b100;
    #1 chk("t3_no_passthru", 32'(bus_ready), 32'd0);
    tick;
    drop_ready = '0;
    #1 chk("t3_bc_ready", 32'(bus_ready), 32'd1);
    tick;
    bus_valid = 1'b0; bus_bcast = 1'b0;
    #1;
    chk("t3_valid", 32'(drop_valid), 32'b111);
    chk("t3_d0", 32'(dd(0)), 32'h5C);
    chk("t3_d1", 32'(dd(1)), 32'h5C);
    chk("t3_d2", 32'(dd(2)), 32'hA1);

    // 4: multi-hot select errors, then counter saturation
    do_reset;
    bus_sel = 3'b011; bus_data = 8'h77; bus_valid = 1'b1;
    #1 chk("t4_ready", 32'(bus_ready), 32'd0);
    tick; chk("t4_err1", 32'(sel_err), 32'd1);
    tick; chk("t4_err2", 32'(sel_err), 32'd1);
    tick;
    bus_valid = 1'b0;
    #1 chk("t4_err3", 32'(sel_err), 32'd1);
    chk("t4_cnt3", 32'(err_cnt), 32'd3);
    tick; chk("t4_err_off", 32'(sel_err), 32'd0);
    chk("t4_novalid", 32'(drop_valid), 32'd0);
    bus_sel = 3'b000; bus_valid = 1'b1;
    repeat (300) tick;
    bus_valid = 1'b0;
    tick;
    chk("t4_sat", 32'(err_cnt), 32'd255);

    // 5: steady push+pop on a half-full drop, then async reset mid-stream
    do_reset;
    bus_sel = 3'b001; bus_valid = 1'b1;
    bus_data = 8'd0; tick;
    bus_data = 8'd1; tick;
    drop_ready = 3'b001;
    for (int k = 0; k < 20; k++) begin
      bus_data = 8'(k + 2);
      #1;
      chk("t5_head", 32'(dd(0)), 32'(k));
      chk("t5_nfull", 32'(drop_full[0]), 32'd0);
      chk("t5_valid", 32'(drop_valid[0]), 32'd1);
      tick;
    end
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(drop_valid), 32'd0);
    chk("t5_rst_full",  32'(drop_full),  32'd0);
    chk("t5_rst_data",  32'(drop_data),  32'd0);
    chk("t5_rst_err",   32'(sel_err),    32'd0);
    chk("t5_rst_cnt",   32'(err_cnt),    32'd0);
    bus_valid = 1'b0; drop_ready = '0;
    tick; tick;
    rst = 1'b0;
    tick; tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
